// File: rtl/issue_scoreboard.sv
// Issue-stage scheduler: pending-write scoreboard plus a writeback-slot reservation
// shift register for the single register-file write port; stalls Decode on hazards.
module issue_scoreboard #(
  parameter int ALU_LAT   = 1,
  parameter int SHIFT_LAT = 2,
  parameter int MEM_LAT   = 3,
  parameter int WB_DEPTH  = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        id_is_valid,
  input  logic        id_is_flush,
  input  logic [1:0]  id_is_numop,
  input  logic [4:0]  id_is_addra,
  input  logic [4:0]  id_is_addrb,
  input  logic [4:0]  id_is_regdest,
  input  logic        id_is_writereg,
  input  logic        id_is_selalushift,
  input  logic        id_is_readmem,
  input  logic        id_is_writemem,
  output logic        is_if_stall,
  output logic        is_ex_issue,
  output logic [1:0]  is_ex_unit,
  output logic [4:0]  is_ex_regdest,
  output logic        is_ex_writereg,
  output logic        wb_reg_valid,
  output logic [4:0]  wb_reg_addr,
  output logic [31:0] sb_pending
);

  localparam logic [1:0] UNIT_ALU   = 2'b00;
  localparam logic [1:0] UNIT_SHIFT = 2'b01;
  localparam logic [1:0] UNIT_MEM   = 2'b10;

  logic [31:0]         pending, pending_nxt;
  logic [WB_DEPTH-1:0] wb_v, wb_v_nxt, lat_mask;
  logic [4:0]          wb_a [WB_DEPTH];
  logic [2:0]          mem_cnt;
  logic [1:0]          unit;
  logic                is_mem, wr, cand, need_a, need_b, busy_a, busy_b;
  logic                raw, waw, strct, wbport, hazard, issue, reserve;

  // Unit select and the one-hot slot a new reservation lands in
  always_comb begin
    is_mem   = id_is_readmem | id_is_writemem;
    unit     = UNIT_ALU;
    lat_mask = WB_DEPTH'(1) << ALU_LAT;
    if (is_mem) begin
      unit     = UNIT_MEM;
      lat_mask = WB_DEPTH'(1) << MEM_LAT;
    end else if (id_is_selalushift) begin
      unit     = UNIT_SHIFT;
      lat_mask = WB_DEPTH'(1) << SHIFT_LAT;
    end
  end

  assign wr     = id_is_writereg & (id_is_regdest != 5'd0);
  assign cand   = id_is_valid & ~id_is_flush;
  assign need_a = (id_is_numop != 2'd0);
  assign need_b = id_is_numop[1];
  // A source retiring this cycle is forwarded, so it is not busy
  assign busy_a = pending[id_is_addra] & ~(wb_v[0] & (wb_a[0] == id_is_addra));
  assign busy_b = pending[id_is_addrb] & ~(wb_v[0] & (wb_a[0] == id_is_addrb));

  assign raw    = (need_a & busy_a) | (need_b & busy_b);
  assign waw    = wr & pending[id_is_regdest];
  assign strct  = is_mem & (mem_cnt != 3'd0);
  // The slot above ours moves into ours at this edge, so it must be free
  assign wbport = wr & (|(wb_v & (lat_mask << 1)));
  assign hazard = raw | waw | strct | wbport;

  assign is_if_stall = cand & hazard;
  assign issue       = cand & ~hazard;
  assign reserve     = issue & wr;
  assign sb_pending  = pending;

  always_comb begin
    pending_nxt = pending;
    if (wb_v[0]) pending_nxt[wb_a[0]] = 1'b0;
    if (reserve) pending_nxt[id_is_regdest] = 1'b1;
    pending_nxt[0] = 1'b0;
    wb_v_nxt = (wb_v >> 1) | (reserve ? lat_mask : '0);
  end

  // Issue -> execute boundary and scoreboard state
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pending        <= '0;
      wb_v           <= '0;
      mem_cnt        <= '0;
      is_ex_issue    <= 1'b0;
      is_ex_unit     <= UNIT_ALU;
      is_ex_regdest  <= '0;
      is_ex_writereg <= 1'b0;
      wb_reg_valid   <= 1'b0;
      wb_reg_addr    <= '0;
      for (int i = 0; i < WB_DEPTH; i++) wb_a[i] <= '0;
    end else begin
      pending <= pending_nxt;
      wb_v    <= wb_v_nxt;
      for (int i = 0; i < WB_DEPTH - 1; i++) begin
        if (reserve && lat_mask[i]) wb_a[i] <= id_is_regdest;
        else                        wb_a[i] <= wb_a[i+1];
      end
      if (reserve && lat_mask[WB_DEPTH-1]) wb_a[WB_DEPTH-1] <= id_is_regdest;
      else                                 wb_a[WB_DEPTH-1] <= '0;
      if (issue && is_mem)        mem_cnt <= 3'(MEM_LAT - 1);
      else if (mem_cnt != 3'd0)   mem_cnt <= mem_cnt - 3'd1;
      is_ex_issue    <= issue;
      is_ex_unit     <= unit;
      is_ex_regdest  <= id_is_regdest;
      is_ex_writereg <= reserve;
      wb_reg_valid   <= wb_v[1];
      wb_reg_addr    <= wb_a[1];
    end
  end

endmodule
